// File: rtl/feature_mem_resp.sv
// feature_mem_resp: feature memory behind a processor. The memory is preloaded
// from a load stream, then the processor runs against it. After done, the
// first DUMP_WORDS words are streamed out, and the block parks in HALT.
// The dump path is built only when FEATURE_MEM_DUMP_EN is defined. Without
// it, done goes straight to HALT and the dump outputs are tied low.
module feature_mem_resp #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int LOAD_WORDS = 4096,
  parameter int DUMP_WORDS = 101
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          start,
  input  logic [AW-1:0] feature_addr,
  input  logic [DW-1:0] feature_data,
  input  logic          feature_mem_en,
  output logic [DW-1:0] feature_idata,
  input  logic          done,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          halted
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_WORDS - 1);
  localparam logic [AW-1:0] DUMP_LAST = AW'(DUMP_WORDS - 1);
`ifdef FEATURE_MEM_DUMP_EN
  localparam state_t        DONE_NEXT = ST_DUMP;
`else
  localparam state_t        DONE_NEXT = ST_HALT;
`endif

  logic [DW-1:0] mem_r [0:DEPTH-1];
  state_t        state_r;
  state_t        state_nx;
  logic [AW-1:0] ld_ptr_r;
  logic          ld_ready_r;
  logic          start_r;
  logic          halted_r;
  logic [DW-1:0] feature_idata_r;
  logic          load_wr_s;
  logic          run_wr_s;
  logic          dump_xfer_s;
  logic          dump_last_s;

  // Writes are only honoured in their own phase, and never while in reset.
  assign load_wr_s = (state_r == ST_LOAD) && ld_valid && ld_ready_r && !reset;
  assign run_wr_s  = (state_r == ST_RUN) && feature_mem_en && !reset;

  // Next-state logic for the LOAD -> RUN -> (DUMP) -> HALT sequence.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_wr_s && (ld_ptr_r == LOAD_LAST)) state_nx = ST_RUN;
        else                                      state_nx = ST_LOAD;
      end
      ST_RUN: begin
        if (done) state_nx = DONE_NEXT;
        else      state_nx = ST_RUN;
      end
      ST_DUMP: begin
        if (dump_xfer_s && dump_last_s) state_nx = ST_HALT;
        else                            state_nx = ST_DUMP;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_LOAD;
    endcase
  end

  // State, load pointer and registered phase strobes (derived from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_LOAD;
      ld_ptr_r   <= {AW{1'b0}};
      ld_ready_r <= 1'b0;
      start_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nx;
      if (load_wr_s) ld_ptr_r <= ld_ptr_r + ONE;
      ld_ready_r <= (state_nx == ST_LOAD);
      start_r    <= (state_nx == ST_RUN);
      halted_r   <= (state_nx == ST_HALT);
    end
  end

  // Single write port shared by the loader (LOAD) and the processor (RUN).
  always_ff @(posedge clk) begin
    if (load_wr_s)     mem_r[ld_ptr_r]     <= ld_data;
    else if (run_wr_s) mem_r[feature_addr] <= feature_data;
  end

  // Processor read port: one-cycle latency, write-first on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset)                  feature_idata_r <= {DW{1'b0}};
    else if (run_wr_s)          feature_idata_r <= feature_data;
    else if (state_r == ST_RUN) feature_idata_r <= mem_r[feature_addr];
  end

`ifdef FEATURE_MEM_DUMP_EN
  logic          dump_valid_r;
  logic [AW-1:0] dump_addr_r;
  logic [DW-1:0] dump_data_r;

  assign dump_xfer_s = dump_valid_r && dump_ready;
  assign dump_last_s = (dump_addr_r == DUMP_LAST);

  // Dump stream: present word 0 one cycle after entry, then prefetch the
  // next word on every transfer so back-to-back transfers have no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_valid_r <= 1'b0;
      dump_addr_r  <= {AW{1'b0}};
      dump_data_r  <= {DW{1'b0}};
    end else if (state_r == ST_DUMP) begin
      if (!dump_valid_r) begin
        dump_valid_r <= 1'b1;
        dump_addr_r  <= {AW{1'b0}};
        dump_data_r  <= mem_r[{AW{1'b0}}];
      end else if (dump_ready) begin
        if (dump_last_s) begin
          dump_valid_r <= 1'b0;
        end else begin
          dump_addr_r <= dump_addr_r + ONE;
          dump_data_r <= mem_r[dump_addr_r + ONE];
        end
      end
    end
  end

  assign dump_valid = dump_valid_r;
  assign dump_addr  = dump_addr_r;
  assign dump_data  = dump_data_r;
`else
  logic unused_dump_ready;

  assign unused_dump_ready = dump_ready;
  assign dump_xfer_s       = 1'b0;
  assign dump_last_s       = 1'b0;
  assign dump_valid        = 1'b0;
  assign dump_addr         = {AW{1'b0}};
  assign dump_data         = {DW{1'b0}};
`endif

  assign ld_ready      = ld_ready_r;
  assign start         = start_r;
  assign halted        = halted_r;
  assign feature_idata = feature_idata_r;

endmodule

// File: tb/tb_feature_mem_resp.sv
// tb_feature_mem_resp: scoreboard bench for feature_mem_resp with small
// parameters (AW=4, LOAD_WORDS=4, DUMP_WORDS=3). The dump-stream sequences
// run when FEATURE_MEM_DUMP_EN is defined; otherwise the direct done->HALT
// behaviour is checked.
module tb_feature_mem_resp;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int DWDS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          start;
  logic [AW-1:0] feature_addr = '0;
  logic [DW-1:0] feature_data = '0;
  logic          feature_mem_en = 1'b0;
  logic [DW-1:0] feature_idata;
  logic          done = 1'b0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          halted;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model [0:15];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] exp_addr_q [$];

  always #5 clk = ~clk;

  feature_mem_resp #(
    .AW(AW), .DW(DW), .LOAD_WORDS(LW), .DUMP_WORDS(DWDS)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start),
    .feature_addr(feature_addr), .feature_data(feature_data),
    .feature_mem_en(feature_mem_en), .feature_idata(feature_idata),
    .done(done),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .halted(halted)
  );

  task automatic chk_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_value({tag, "_start"}, start, 1'b0);
    chk_value({tag, "_ld_ready"}, ld_ready, 1'b0);
    chk_value({tag, "_dump_valid"}, dump_valid, 1'b0);
    chk_value({tag, "_dump_addr"}, dump_addr, '0);
    chk_value({tag, "_halted"}, halted, 1'b0);
  endtask

  // Load LW words 0x11*(k+i); optionally attempt a processor write to address 0.
  task automatic load_all(input int k, input bit try_write);
    int idx = 0;
    int budget = 0;
    bit acc;
    logic [DW-1:0] w;
    while (idx < LW && budget < 40) begin
      w = 32'h11 * (k + idx);
      ld_valid = 1'b1;
      ld_data  = w;
      if (try_write) begin
        feature_mem_en = 1'b1;
        feature_addr   = '0;
        feature_data   = 32'hBAD0BAD0;
      end
      if (budget == 1) chk_value("start_low_in_load", start, 1'b0);
      acc = ld_ready;
      tick();
      if (acc) begin
        model[idx] = w;
        idx++;
      end
      budget++;
    end
    ld_valid = 1'b0;
    feature_mem_en = 1'b0;
    chk_value("load_accepts", idx, LW);
    chk_value("start_after_load", start, 1'b1);
    chk_value("ld_ready_in_run", ld_ready, 1'b0);
  endtask

  // One RUN cycle: drive address (and optional write), check read data next cycle.
  task automatic run_op(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] d);
    feature_addr   = a;
    feature_mem_en = wr;
    feature_data   = d;
    if (wr) begin
      model[a] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model[a]);
    end
    tick();
    feature_mem_en = 1'b0;
    chk_value("feature_idata", feature_idata, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_reset_state("reset");
    chk_value("reset_idata", feature_idata, '0);
    chk_value("reset_dump_data", dump_data, '0);
    reset = 1'b0;

    // Load with a concurrent (ignored) processor write to address 0
    load_all(1, 1'b1);

    // RUN reads and writes, including write-first on the same address
    run_op(4'd2, 1'b0, '0);
    run_op(4'd0, 1'b0, '0);
    run_op(4'd3, 1'b0, '0);
    run_op(4'd5, 1'b1, 32'hDEADBEEF);
    run_op(4'd5, 1'b0, '0);
    run_op(4'd7, 1'b1, 32'h12345678);
    run_op(4'd1, 1'b0, '0);
    run_op(4'd7, 1'b0, '0);
    chk_value("start_held_in_run", start, 1'b1);

`ifdef FEATURE_MEM_DUMP_EN
    begin
      bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int step = 0;
      int budget = 0;
      for (int i = 0; i < DWDS; i++) begin
        exp_q.push_back(model[i]);
        exp_addr_q.push_back(AW'(i));
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_value("start_low_in_dump", start, 1'b0);
      chk_value("dump_valid_entry", dump_valid, 1'b0);
      while (exp_q.size() > 0 && budget < 30) begin
        if (dump_valid) begin
          dump_ready = (step < 4) ? pat[step] : 1'b1;
          step++;
          chk_value("dump_addr", dump_addr, exp_addr_q[0]);
          chk_value("dump_data", dump_data, exp_q[0]);
          if (dump_ready) begin
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
          end
        end else begin
          dump_ready = 1'b0;
        end
        tick();
        budget++;
      end
      dump_ready = 1'b0;
      chk_value("dump_words_left", exp_q.size(), 0);
      chk_value("dump_halted", halted, 1'b1);
      chk_value("dump_valid_after", dump_valid, 1'b0);
    end

    // Second pass: reset, reload, then reset in the middle of DUMP
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_all(5, 1'b0);
    run_op(4'd5, 1'b0, '0);
    done = 1'b1;
    tick();
    done = 1'b0;
    begin
      int budget = 0;
      while (!dump_valid && budget < 10) begin
        tick();
        budget++;
      end
      chk_value("dump_valid_seen", dump_valid, 1'b1);
    end
    reset = 1'b1;
    tick();
    chk_reset_state("mid_dump_reset");
    reset = 1'b0;
    load_all(9, 1'b0);
    run_op(4'd5, 1'b0, '0);
    run_op(4'd2, 1'b0, '0);
`else
    dump_ready = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_value("halted_after_done", halted, 1'b1);
    chk_value("start_after_done", start, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_value("dump_valid_tied", dump_valid, 1'b0);
      chk_value("halted_held", halted, 1'b1);
    end
    dump_ready = 1'b0;

    // Reset out of HALT; memory keeps contents across reset
    reset = 1'b1;
    tick();
    chk_reset_state("halt_reset");
    reset = 1'b0;
    load_all(5, 1'b0);
    run_op(4'd5, 1'b0, '0);
    run_op(4'd1, 1'b0, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
